// File: rtl/half_adder_reg.sv
// Per-lane registered half adder: sum = in1 ^ in2, carry = in1 & in2, lanes independent.
// Latency: one clock from an accepted input to sum/carry/out_valid.
// Backpressure: none; a new input is accepted on every cycle with in_valid high.
module half_adder_reg #(
    parameter int WIDTH           = 1,
    parameter bit ZERO_ON_INVALID = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= in1 ^ in2;
                carry <= in1 & in2;
            end else if (ZERO_ON_INVALID) begin
                sum   <= '0;
                carry <= '0;
            end
            // With ZERO_ON_INVALID clear, an idle cycle keeps the last result.
        end
    end

endmodule

// File: tb/tb_half_adder_reg.sv
// Bench for half_adder_reg: three instances (W=1 clearing, W=8 clearing, W=13 holding)
// driven in lockstep and compared against a lane-arithmetic reference model.
module tb_half_adder_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [0:0]  a1, b1, s1, c1;
    logic [7:0]  a8, b8, s8, c8;
    logic [12:0] a13, b13, s13, c13;
    logic        v1, v8, v13;

    half_adder_reg #(.WIDTH(1), .ZERO_ON_INVALID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in1(a1), .in2(b1), .in_valid(in_valid),
        .sum(s1), .carry(c1), .out_valid(v1)
    );
    half_adder_reg #(.WIDTH(8), .ZERO_ON_INVALID(1'b1)) dut8 (
        .clk(clk), .rst(rst), .in1(a8), .in2(b8), .in_valid(in_valid),
        .sum(s8), .carry(c8), .out_valid(v8)
    );
    half_adder_reg #(.WIDTH(13), .ZERO_ON_INVALID(1'b0)) dut13 (
        .clk(clk), .rst(rst), .in1(a13), .in2(b13), .in_valid(in_valid),
        .sum(s13), .carry(c13), .out_valid(v13)
    );

    logic [63:0] es1, ec1, es8, ec8, es13, ec13;
    logic        ev;
    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  truth [4];

    // Each lane adds two one-bit numbers: low bit of the total is sum, high bit is carry.
    function automatic logic [127:0] add_lanes(input logic [63:0] a, input logic [63:0] b,
                                               input int w);
        logic [63:0] s, c;
        int          t;
        s = '0;
        c = '0;
        for (int i = 0; i < w; i++) begin
            t    = int'(a[i]) + int'(b[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        cmp("w1_sum", 64'(s1), es1);
        cmp("w1_carry", 64'(c1), ec1);
        cmp("w1_valid", 64'(v1), 64'(ev));
        cmp("w8_sum", 64'(s8), es8);
        cmp("w8_carry", 64'(c8), ec8);
        cmp("w8_valid", 64'(v8), 64'(ev));
        cmp("w13_sum", 64'(s13), es13);
        cmp("w13_carry", 64'(c13), ec13);
        cmp("w13_valid", 64'(v13), 64'(ev));
        cmp("w1_exclusive", 64'(s1 & c1), 64'd0);
        cmp("w8_exclusive", 64'(s8 & c8), 64'd0);
        cmp("w13_exclusive", 64'(s13 & c13), 64'd0);
    endtask

    // Advance one edge, update the model from the values that edge sampled, then check.
    task automatic step();
        logic [127:0] r;
        @(posedge clk);
        if (rst) begin
            {es1, ec1, es8, ec8, es13, ec13} = '0;
            ev = 1'b0;
        end else begin
            ev = in_valid;
            if (in_valid) begin
                r = add_lanes(64'(a1), 64'(b1), 1);
                {ec1, es1} = r;
                r = add_lanes(64'(a8), 64'(b8), 8);
                {ec8, es8} = r;
                r = add_lanes(64'(a13), 64'(b13), 13);
                {ec13, es13} = r;
            end else begin
                {es1, ec1, es8, ec8} = '0;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        truth[0] = 2'b00;
        truth[1] = 2'b01;
        truth[2] = 2'b01;
        truth[3] = 2'b10;

        // Reset overrides a valid all-ones input on the same edge.
        rst = 1'b1; in_valid = 1'b1;
        a1 = '1; b1 = '1; a8 = '1; b8 = '1; a13 = '1; b13 = '1;
        step();
        step();
        cmp("reset_sum_w1", 64'(s1), 64'd0);
        cmp("reset_valid_w13", 64'(v13), 64'd0);

        // Full truth table on consecutive edges.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a1 = k[1]; b1 = k[0];
            a8 = 8'h00; b8 = 8'h00; a13 = 13'h0; b13 = 13'h0;
            step();
            cmp("truth_table", 64'({c1, s1}), 64'(truth[k]));
            cmp("truth_valid", 64'(v1), 64'd1);
        end

        // Lanes are independent: no carry ripples across the byte.
        a8 = 8'hF0; b8 = 8'hCC; a13 = 13'h1FFF; b13 = 13'h0AAA;
        step();
        cmp("byte_sum", 64'(s8), 64'h3C);
        cmp("byte_carry", 64'(c8), 64'hC0);

        // Idle cycle: clearing instances zero, holding instance keeps the last result.
        in_valid = 1'b0; a13 = 13'h0; b13 = 13'h0;
        step();
        cmp("idle_clear_sum", 64'(s8), 64'h0);
        cmp("idle_hold_sum", 64'(s13), 64'h1555);
        cmp("idle_hold_carry", 64'(c13), 64'h0AAA);
        cmp("idle_valid", 64'(v13), 64'd0);

        // Steady 1+1 for 100 cycles.
        in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            cmp("steady_carry", 64'({c1, s1, v1}), 64'b101);
        end

        // Reset and valid together, then the first post-reset input.
        rst = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        step();
        cmp("rst_vs_valid", 64'({c1, s1, v1}), 64'b000);
        rst = 1'b0; a1 = 1'b0; b1 = 1'b1; a8 = 8'h0F; b8 = 8'h3C;
        step();
        cmp("post_rst_w1", 64'({c1, s1, v1}), 64'b011);
        cmp("post_rst_w8_sum", 64'(s8), 64'h33);
        cmp("post_rst_w8_carry", 64'(c8), 64'h0C);

        // Random traffic with sparse idles and occasional mid-stream resets.
        for (int k = 0; k < 10000; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            a1  = 1'($urandom);  b1  = 1'($urandom);
            a8  = 8'($urandom);  b8  = 8'($urandom);
            a13 = 13'($urandom); b13 = 13'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
